// File: rtl/orb_descriptor_sampler_if.sv
// Bundle of the run request, rotated offsets, patch RAM read port and descriptor handshake
// for the ORB descriptor sampler.
interface orb_descriptor_sampler_if #(
    parameter int BW_OUT  = 6,
    parameter int NPAIR   = 128,
    parameter int BW_PIX  = 8,
    parameter int BW_ADDR = 11
);
    logic                      start;
    logic [NPAIR*BW_OUT-1:0]   xa;
    logic [NPAIR*BW_OUT-1:0]   ya;
    logic [NPAIR*BW_OUT-1:0]   xb;
    logic [NPAIR*BW_OUT-1:0]   yb;
    logic                      busy;
    logic                      rd_en;
    logic [BW_ADDR-1:0]        rd_addr;
    logic [BW_PIX-1:0]         rd_data;
    logic [NPAIR-1:0]          desc;
    logic                      desc_valid;
    logic                      desc_ready;

    // master: the environment (offset source, patch RAM, descriptor sink)
    modport master (
        output start, xa, ya, xb, yb, rd_data, desc_ready,
        input  busy, rd_en, rd_addr, desc, desc_valid
    );

    // slave: the sampler itself
    modport slave (
        input  start, xa, ya, xb, yb, rd_data, desc_ready,
        output busy, rd_en, rd_addr, desc, desc_valid
    );
endinterface

// File: rtl/orb_descriptor_sampler.sv
// Fetches NPAIR rotated BRIEF point pairs from a smoothed-patch RAM, compares each pair
// and hands the resulting NPAIR-bit descriptor chunk downstream on a valid/ready handshake.
module orb_descriptor_sampler #(
    parameter int BW_OUT  = 6,
    parameter int NPAIR   = 128,
    parameter int PATCH   = 37,
    parameter int BW_PIX  = 8,
    parameter int BW_ADDR = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    orb_descriptor_sampler_if.slave  bus
);
    localparam int HALF  = (PATCH - 1) / 2;
    localparam int CNT_W = $clog2(2 * NPAIR) + 1;
    localparam int PW    = $clog2(NPAIR);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(2 * NPAIR - 1);
    localparam logic [PW:0]      LAST_IDX = LAST[PW:0];

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [NPAIR*BW_OUT-1:0]   xa_q, ya_q, xb_q, yb_q;
    logic [PW-1:0]             pair;
    logic signed [BW_OUT-1:0]  off_x, off_y;
    logic [PW:0]               idx_p1, idx_p2;
    logic                      vld_p2;
    logic [BW_PIX-1:0]         pix_a_p2;
    logic [NPAIR-1:0]          bits, bits_nxt;
    logic                      load, issue, last_ret, accept;

    // Clamp an offset to the patch half-width so off-patch points read the border.
    function automatic int sat_off(input logic signed [BW_OUT-1:0] v);
        int t;
        t = int'(v);
        if (t > HALF)  return HALF;
        if (t < -HALF) return -HALF;
        return t;
    endfunction

    function automatic logic [BW_ADDR-1:0] pix_addr(input logic signed [BW_OUT-1:0] x,
                                                    input logic signed [BW_OUT-1:0] y);
        return BW_ADDR'((HALF + sat_off(y)) * PATCH + HALF + sat_off(x));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)     state_nxt = FETCH;
            FETCH:   if (cnt == LAST)   state_nxt = DRAIN;
            DRAIN:   if (last_ret)      state_nxt = DONE;
            DONE:    if (accept)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && bus.start;
        issue    = (state == FETCH);
        last_ret = vld_p2 && (idx_p2 == LAST_IDX);
        accept   = (state == DONE) && bus.desc_valid && bus.desc_ready;
    end

    // Stage p0: even count reads point A, odd count reads point B of pair cnt>>1
    always_comb begin
        pair  = cnt[PW:1];
        off_x = cnt[0] ? xb_q[pair*BW_OUT +: BW_OUT] : xa_q[pair*BW_OUT +: BW_OUT];
        off_y = cnt[0] ? yb_q[pair*BW_OUT +: BW_OUT] : ya_q[pair*BW_OUT +: BW_OUT];
    end

    // Stage p2: pixel returns; a B pixel resolves its pair against the held A pixel
    always_comb begin
        bits_nxt = bits;
        if (vld_p2 && idx_p2[0])
            bits_nxt[idx_p2[PW:1]] = (pix_a_p2 < bus.rd_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.desc       <= '0;
            bus.desc_valid <= 1'b0;
            vld_p2         <= 1'b0;
        end else begin
            bus.busy  <= (state_nxt != IDLE);
            bus.rd_en <= issue;
            vld_p2    <= bus.rd_en;
            if (load)
                cnt <= '0;
            else if (issue)
                cnt <= cnt + 1'b1;
            if (issue)
                bus.rd_addr <= pix_addr(off_x, off_y);
            if ((state == DRAIN) && last_ret) begin
                bus.desc       <= bits_nxt;
                bus.desc_valid <= 1'b1;
            end else if (accept) begin
                bus.desc_valid <= 1'b0;
            end
        end
    end

    // Stage p1: read index travels with the RAM request; data registers carry no reset
    always_ff @(posedge clk) begin
        if (load) begin
            xa_q <= bus.xa;
            ya_q <= bus.ya;
            xb_q <= bus.xb;
            yb_q <= bus.yb;
        end
        if (issue)
            idx_p1 <= cnt[PW:0];
        idx_p2 <= idx_p1;
        if (vld_p2 && !idx_p2[0])
            pix_a_p2 <= bus.rd_data;
        bits <= bits_nxt;
    end
endmodule

// File: tb/tb_orb_descriptor_sampler.sv
// Self-checking bench for orb_descriptor_sampler: patch RAM model, reference descriptor
// model and an expected-descriptor queue.
module tb_orb_descriptor_sampler;
    localparam int BW_OUT  = 6;
    localparam int NPAIR   = 128;
    localparam int PATCH   = 37;
    localparam int BW_PIX  = 8;
    localparam int BW_ADDR = 11;
    localparam int CTR     = (PATCH - 1) / 2;
    localparam int NPIX    = PATCH * PATCH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [BW_PIX-1:0] mem [0:NPIX-1];
    logic [NPAIR-1:0]  exp_q [$];

    orb_descriptor_sampler_if #(.BW_OUT(BW_OUT), .NPAIR(NPAIR), .BW_PIX(BW_PIX),
                                .BW_ADDR(BW_ADDR)) bus ();

    orb_descriptor_sampler #(.BW_OUT(BW_OUT), .NPAIR(NPAIR), .PATCH(PATCH),
                             .BW_PIX(BW_PIX), .BW_ADDR(BW_ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous patch RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    function automatic int ref_addr(input logic [BW_OUT-1:0] xv, input logic [BW_OUT-1:0] yv);
        int x, y;
        x = int'($signed(xv));
        y = int'($signed(yv));
        x = (x > CTR) ? CTR : ((x < -CTR) ? -CTR : x);
        y = (y > CTR) ? CTR : ((y < -CTR) ? -CTR : y);
        return (CTR + y) * PATCH + (CTR + x);
    endfunction

    function automatic logic [NPAIR-1:0] ref_desc();
        logic [NPAIR-1:0] d;
        int pa, pb;
        for (int i = 0; i < NPAIR; i++) begin
            pa = int'(mem[ref_addr(bus.xa[i*BW_OUT +: BW_OUT], bus.ya[i*BW_OUT +: BW_OUT])]);
            pb = int'(mem[ref_addr(bus.xb[i*BW_OUT +: BW_OUT], bus.yb[i*BW_OUT +: BW_OUT])]);
            d[i] = (pa < pb);
        end
        return d;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++)
                mem[r*PATCH + c] = BW_PIX'(c);
    endtask

    task automatic set_offsets(input int ax, input int ay, input int bx, input int by);
        for (int i = 0; i < NPAIR; i++) begin
            bus.xa[i*BW_OUT +: BW_OUT] = BW_OUT'(ax);
            bus.ya[i*BW_OUT +: BW_OUT] = BW_OUT'(ay);
            bus.xb[i*BW_OUT +: BW_OUT] = BW_OUT'(bx);
            bus.yb[i*BW_OUT +: BW_OUT] = BW_OUT'(by);
        end
    endtask

    task automatic scramble_offsets();
        for (int i = 0; i < NPAIR; i++) begin
            bus.xa[i*BW_OUT +: BW_OUT] = BW_OUT'($urandom);
            bus.ya[i*BW_OUT +: BW_OUT] = BW_OUT'($urandom);
            bus.xb[i*BW_OUT +: BW_OUT] = BW_OUT'($urandom);
            bus.yb[i*BW_OUT +: BW_OUT] = BW_OUT'($urandom);
        end
    endtask

    // Starts one run from a negedge in IDLE and follows it to the accept handshake.
    task automatic run(input int stall_pct, input bit noise, output logic [NPAIR-1:0] got,
                       output int nreads, output int first_addr, output int vcyc,
                       output bit aconst, output bit done);
        int  cyc;
        bit  rdy;
        got = '0; nreads = 0; first_addr = -1; vcyc = -1; aconst = 1'b1; done = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        cyc = 0;
        bus.start = 1'b0;
        if (noise) scramble_offsets();
        while (!done && cyc < 3000) begin
            if (bus.rd_en) begin
                if (nreads == 0) first_addr = int'(bus.rd_addr);
                else if (int'(bus.rd_addr) != first_addr) aconst = 1'b0;
                nreads++;
            end
            if (bus.desc_valid && vcyc < 0) vcyc = cyc;
            rdy = ($urandom_range(99) >= stall_pct);
            if (bus.desc_valid && rdy) begin
                got  = bus.desc;
                done = 1'b1;
            end
            bus.desc_ready = rdy;
            if (noise) bus.start = $urandom_range(1);
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        bus.desc_ready = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.rd_en, bus.rd_addr, bus.desc, bus.desc_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs busy=%b rd_en=%b rd_addr=%0d desc_valid=%b desc=%h required all 0",
                     bus.busy, bus.rd_en, bus.rd_addr, bus.desc_valid, bus.desc);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_flat();
        logic [NPAIR-1:0] got, e;
        int nr, fa, vc;
        bit ac, dn;
        fill_ramp();
        set_offsets(0, 0, 0, 0);
        exp_q.push_back(ref_desc());
        run(0, 1'b0, got, nr, fa, vc, ac, dn);
        e = exp_q.pop_front();
        vectors++; if (!dn) begin miscompares++; $display("FAIL flat_timeout got no handshake, required one"); end
        vectors++; if (nr !== 256) begin miscompares++; $display("FAIL flat_reads got %0d required 256", nr); end
        vectors++; if (fa !== 684 || !ac) begin miscompares++; $display("FAIL flat_addr got first %0d const=%b required 684 const=1", fa, ac); end
        vectors++; if (got !== e) begin miscompares++; $display("FAIL flat_desc got %h required %h", got, e); end
        vectors++; if (bus.desc_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL flat_idle valid=%b busy=%b required 0 0", bus.desc_valid, bus.busy);
        end
    endtask

    task automatic test_ramp_slope();
        logic [NPAIR-1:0] got, e;
        int nr, fa, vc;
        bit ac, dn;
        fill_ramp();
        set_offsets(-1, 0, 1, 0);
        exp_q.push_back(ref_desc());
        run(0, 1'b0, got, nr, fa, vc, ac, dn);
        e = exp_q.pop_front();
        vectors++; if (got !== e) begin miscompares++; $display("FAIL slope_desc got %h required %h", got, e); end
        vectors++; if (vc !== 258) begin miscompares++; $display("FAIL slope_valid_cycle got %0d required 258", vc); end
        vectors++; if (fa !== 683) begin miscompares++; $display("FAIL slope_first_addr got %0d required 683", fa); end
    endtask

    task automatic test_clamp();
        logic [NPAIR-1:0] got, e;
        int nr, fa, vc;
        bit ac, dn;
        fill_ramp();
        set_offsets(0, 0, 0, 0);
        bus.xa[0 +: BW_OUT] = BW_OUT'(3);
        bus.ya[0 +: BW_OUT] = BW_OUT'(-2);
        exp_q.push_back(ref_desc());
        run(0, 1'b0, got, nr, fa, vc, ac, dn);
        e = exp_q.pop_front();
        vectors++; if (fa !== 613) begin miscompares++; $display("FAIL offset_addr got %0d required 613", fa); end
        vectors++; if (got !== e) begin miscompares++; $display("FAIL offset_desc got %h required %h", got, e); end
        bus.xa[0 +: BW_OUT] = BW_OUT'(-25);
        bus.ya[0 +: BW_OUT] = BW_OUT'(31);
        exp_q.push_back(ref_desc());
        run(0, 1'b0, got, nr, fa, vc, ac, dn);
        e = exp_q.pop_front();
        vectors++; if (fa !== 1332) begin miscompares++; $display("FAIL clamp_addr got %0d required 1332", fa); end
        vectors++; if (got !== e) begin miscompares++; $display("FAIL clamp_desc got %h required %h", got, e); end
    endtask

    task automatic test_backpressure();
        logic [NPAIR-1:0] d0, e;
        int cyc;
        fill_ramp();
        set_offsets(-1, 0, 1, 0);
        bus.xa[5*BW_OUT +: BW_OUT] = BW_OUT'(4);
        exp_q.push_back(ref_desc());
        bus.desc_ready = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.desc_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (!bus.desc_valid) begin
            miscompares++;
            $display("FAIL bp_timeout desc_valid=%b after %0d cycles, required 1", bus.desc_valid, cyc);
        end
        d0 = bus.desc;
        e = exp_q.pop_front();
        vectors++; if (d0 !== e) begin miscompares++; $display("FAIL bp_desc got %h required %h", d0, e); end
        for (int k = 0; k < 10; k++) begin
            bus.start = k[0];
            @(negedge clk);
            vectors++;
            if (bus.desc_valid !== 1'b1 || bus.desc !== d0 || bus.busy !== 1'b1 || bus.rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold k=%0d valid=%b busy=%b rd_en=%b desc_changed=%b required 1 1 0 0",
                         k, bus.desc_valid, bus.busy, bus.rd_en, bus.desc !== d0);
            end
        end
        bus.start = 1'b1;
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.desc_ready = 1'b0;
        vectors++;
        if (bus.desc_valid !== 1'b0 || bus.busy !== 1'b0 || bus.desc !== d0) begin
            miscompares++;
            $display("FAIL bp_accept valid=%b busy=%b desc_kept=%b required 0 0 1",
                     bus.desc_valid, bus.busy, bus.desc === d0);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_no_requeue rd_en=%b busy=%b required 0 0", bus.rd_en, bus.busy);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [NPAIR-1:0] got, e;
        int nr, fa, vc, cyc;
        bit ac, dn;
        fill_ramp();
        set_offsets(2, 1, -3, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (bus.rd_en !== 1'b1) begin miscompares++; $display("FAIL midrun_fetching rd_en=%b required 1", bus.rd_en); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.rd_en, bus.rd_addr, bus.desc, bus.desc_valid} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset busy=%b rd_en=%b rd_addr=%0d desc_valid=%b desc=%h required all 0",
                     bus.busy, bus.rd_en, bus.rd_addr, bus.desc_valid, bus.desc);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL midrun_quiet rd_en=%b busy=%b required 0 0", bus.rd_en, bus.busy);
        end
        set_offsets(-1, 0, 1, 0);
        bus.xb[7*BW_OUT +: BW_OUT] = BW_OUT'(-5);
        exp_q.push_back(ref_desc());
        run(0, 1'b0, got, nr, fa, vc, ac, dn);
        e = exp_q.pop_front();
        vectors++; if (got !== e) begin miscompares++; $display("FAIL rerun_desc got %h required %h", got, e); end
        vectors++; if (nr !== 256 || vc !== 258) begin
            miscompares++; $display("FAIL rerun_timing reads %0d valid_cycle %0d required 256 258", nr, vc);
        end
    endtask

    task automatic test_back_to_back();
        logic [NPAIR-1:0] got, e;
        int nr, fa, vc, span;
        bit ac, dn;
        for (int r = 0; r < 200; r++) begin
            span = (r % 4 == 0) ? 3 : 255;
            for (int p = 0; p < NPIX; p++) mem[p] = BW_PIX'($urandom_range(span));
            scramble_offsets();
            exp_q.push_back(ref_desc());
            run(25, 1'b1, got, nr, fa, vc, ac, dn);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e || !dn) begin
                miscompares++; $display("FAIL rand_desc run=%0d got %h required %h", r, got, e);
            end
            vectors++;
            if (nr !== 256 || vc !== 258) begin
                miscompares++; $display("FAIL rand_timing run=%0d reads %0d valid_cycle %0d required 256 258", r, nr, vc);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.desc_ready = 1'b0;
        set_offsets(0, 0, 0, 0);
        fill_ramp();
        test_reset();
        test_ramp_flat();
        test_ramp_slope();
        test_clamp();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
